// File: rtl/mdu_unit_if.sv
// mdu_unit_if: operation request and HI/LO result bundle between controller and MDU
interface mdu_unit_if;
  logic        start;
  logic [2:0]  mdu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  modport master (output start, mdu_op, a, b, input busy, done, hi, lo);
  modport slave  (input start, mdu_op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave m
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     op_q, op_d;
  logic [31:0]    a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic           done_q, done_d;
  logic [63:0]    prod_u;
  logic signed [63:0] prod_s;
  logic signed [31:0] sa, sb, qs, rs;
  logic           ovf;
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign ovf    = a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF;
  assign sa     = a_q;
  assign sb     = (b_q == 32'b0 || ovf) ? 32'sd1 : b_q;
  assign qs     = sa / sb;
  assign rs     = sa % sb;
  // Next-state: launch/moves in IDLE, countdown and result write-back in RUN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (m.start && !m.mdu_op[2]) begin
        state_d = RUN;
        cnt_d   = m.mdu_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        op_d    = m.mdu_op[1:0];
        a_d     = m.a;
        b_d     = m.b;
      end else if (m.start && m.mdu_op == 3'b100) begin
        hi_d = m.a;
      end else if (m.start && m.mdu_op == 3'b101) begin
        lo_d = m.a;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!op_q[1]) begin
          {hi_d, lo_d} = op_q[0] ? prod_u : prod_s;
        end else if (b_q != 32'b0) begin
          hi_d = ovf ? 32'b0 : (op_q[0] ? a_q % b_q : rs);
          lo_d = ovf ? a_q : (op_q[0] ? a_q / b_q : qs);
        end
      end
    end
  end
  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end
  assign m.busy = state_q == RUN;
  assign m.done = done_q;
  assign m.hi   = hi_q;
  assign m.lo   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: vector table, corner sequences and random ops against a behavioural model
module tb_mdu_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;
  mdu_unit_if s();
  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .m(s.slave));
  always #5 clk = ~clk;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h at %0t", nm, got, want, $time);
    end
  endtask
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic [31:0] ma, mb, q, r;
    case (op)
      3'd0: begin
        p = longint'(signed'(a)) * longint'(signed'(b));
        {exp_hi, exp_lo} = p;
      end
      3'd1: {exp_hi, exp_lo} = {32'b0, a} * {32'b0, b};
      3'd2: if (b != 0) begin
        ma = a[31] ? -a : a;
        mb = b[31] ? -b : b;
        q = ma / mb;
        r = ma % mb;
        exp_lo = (a[31] ^ b[31]) ? -q : q;
        exp_hi = a[31] ? -r : r;
      end
      3'd3: if (b != 0) begin
        exp_lo = a / b;
        exp_hi = a % b;
      end
      3'd4: exp_hi = a;
      3'd5: exp_lo = a;
      default: ;
    endcase
  endtask
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string nm);
    int n;
    n = op[1] ? 10 : 5;
    s.start = 1'b1; s.mdu_op = op; s.a = a; s.b = b;
    @(negedge clk);
    s.start = 1'b0; s.a = $urandom; s.b = $urandom;
    for (int i = 0; i < n; i++) begin
      chk({nm, " busy"}, 32'(s.busy), 32'd1);
      chk({nm, " done_early"}, 32'(s.done), 32'd0);
      if (i < n - 1) @(negedge clk);
    end
    @(negedge clk);
    chk({nm, " busy_end"}, 32'(s.busy), 32'd0);
    chk({nm, " done"}, 32'(s.done), 32'd1);
    chk({nm, " hi"}, s.hi, exp_hi);
    chk({nm, " lo"}, s.lo, exp_lo);
  endtask
  task automatic move(input logic [2:0] op, input logic [31:0] a, input string nm);
    s.start = 1'b1; s.mdu_op = op; s.a = a; s.b = $urandom;
    @(negedge clk);
    s.start = 1'b0;
    chk({nm, " busy"}, 32'(s.busy), 32'd0);
    chk({nm, " done"}, 32'(s.done), 32'd0);
    chk({nm, " hi"}, s.hi, exp_hi);
    chk({nm, " lo"}, s.lo, exp_lo);
  endtask
  task automatic idle_chk(input string nm);
    @(negedge clk);
    chk({nm, " busy"}, 32'(s.busy), 32'd0);
    chk({nm, " done"}, 32'(s.done), 32'd0);
    chk({nm, " hi"}, s.hi, exp_hi);
    chk({nm, " lo"}, s.lo, exp_lo);
  endtask
  initial begin
    vec_t vecs[$];
    logic [2:0] op;
    logic [31:0] ra, rb;
    s.start = 1'b0; s.mdu_op = '0; s.a = '0; s.b = '0;
    vecs.push_back('{3'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001});
    vecs.push_back('{3'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{3'd3, 32'd7,         32'd2,         32'd1,         32'd3});
    vecs.push_back('{3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000});
    vecs.push_back('{3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000});
    vecs.push_back('{3'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'h10,        32'hF,         32'h0FFF_FFFF});
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle_chk("reset_idle");
    foreach (vecs[i]) begin
      exp_hi = vecs[i].hi;
      exp_lo = vecs[i].lo;
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      idle_chk($sformatf("vec%0d_after", i));
    end
    exp_hi = 32'h1234_5678;
    move(3'd4, 32'h1234_5678, "mthi");
    exp_lo = 32'h9ABC_DEF0;
    move(3'd5, 32'h9ABC_DEF0, "mtlo");
    run_op(3'd3, 32'd55, 32'd0, "divu_by0");
    run_op(3'd2, 32'hFFFF_FF00, 32'd0, "div_by0_done_cycle");
    idle_chk("by0_after");
    s.start = 1'b1; s.mdu_op = 3'd2; s.a = 32'd100; s.b = 32'd7;
    @(negedge clk);
    s.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    s.start = 1'b1; s.mdu_op = 3'd0; s.a = 32'd5; s.b = 32'd9;
    @(negedge clk);
    s.start = 1'b0;
    for (int i = 4; i <= 10; i++) begin
      chk("midop busy", 32'(s.busy), 32'd1);
      @(negedge clk);
    end
    exp_hi = 32'd2; exp_lo = 32'd14;
    chk("midop done", 32'(s.done), 32'd1);
    chk("midop hi", s.hi, exp_hi);
    chk("midop lo", s.lo, exp_lo);
    s.start = 1'b1; s.mdu_op = 3'd3; s.a = 32'd1000; s.b = 32'd3;
    @(negedge clk);
    s.start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;
    chk("abort busy", 32'(s.busy), 32'd0);
    chk("abort done", 32'(s.done), 32'd0);
    chk("abort hi", s.hi, exp_hi);
    chk("abort lo", s.lo, exp_lo);
    for (int i = 0; i < 10; i++) idle_chk("abort_idle");
    exp_hi = 32'hAAAA_0001;
    move(3'd4, 32'hAAAA_0001, "mthi2");
    move(3'd6, 32'h5555_5555, "rsv110");
    move(3'd7, 32'h6666_6666, "rsv111");
    idle_chk("rsv_after");
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 5));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 300)));
      model(op, ra, rb);
      if (op <= 3'd3) run_op(op, ra, rb, $sformatf("rnd%0d op%0d", k, op));
      else move(op, ra, $sformatf("rnd%0d op%0d", k, op));
      if ($urandom_range(0, 2) == 0) idle_chk($sformatf("rnd%0d_gap", k));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the MIPS datapath. Serves the mult/multu/div/divu/mthi/mtlo instructions.
- Consumes a 3-bit operation code from the control decoders. This is the control-code consumer side, alongside the combinational ALU.
- Asserts busy so the pipeline and controller stall mfhi/mflo and further MDU instructions until results are valid.

Parameters:
- MULT_CYCLES, 5: busy cycles for mult/multu (must be >=1).
- DIV_CYCLES, 10: busy cycles for div/divu (must be >=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  launch op in mdu_op this cycle.
- mdu_op  input  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110/111 reserved.
- a  input  32  operand rs.
- b  input  32  operand rt.
- busy  output  1  operation in flight.
- done  output  1  one-cycle pulse: hi/lo just updated by mult/div.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset (sampled at a rising edge): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, latched operands/op cleared.
- Reset mid-operation aborts the op; no result is written.
- States: IDLE, RUN.
- IDLE, start=1, op in {mult, multu, div, divu}:
  - latch a, b and op; load counter with MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN timing:
  - busy=1 for exactly N cycles after the start edge (start at cycle T -> busy high in T+1..T+N).
  - Counter decrements each cycle.
  - On the edge ending cycle T+N, hi/lo are written and the unit returns to IDLE.
  - In cycle T+N+1: busy=0, done=1 (done lasts one cycle), new hi/lo visible.
- Operands are used only from the latch; a/b changes during RUN have no effect.
- IDLE, start=1, mthi: hi<=a at that edge (visible T+1); no busy, no done. mtlo likewise writes lo.
- start=1 with a reserved op: ignored; no state change.
- start=1 while busy=1: ignored; the in-flight op completes unchanged. The controller must not issue it; the unit tolerates it anyway.
- start=1 in the done cycle: accepted normally (unit is IDLE).
- mult: {hi,lo} = signed(a) * signed(b), 64-bit two's-complement product.
- multu: {hi,lo} = unsigned 64-bit product.
- div: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - Special case a=0x80000000, b=0xFFFFFFFF: lo=0x80000000, hi=0.
- divu: unsigned lo = a/b, hi = a%b.
- Divide by zero (b=0, div or divu):
  - full DIV_CYCLES busy period and done pulse still occur;
  - hi and lo are left unchanged.
- Result may be computed combinationally at the final cycle or iteratively. Only the busy/done timing and final values above are observable and required.
- hi/lo hold their values at all times except reset, mthi/mtlo and op completion.

Test Plan:
- Reset then idle 3 cycles -> hi=0, lo=0, busy=0, done=0 throughout.
- mult a=0xFFFFFFFE(-2), b=3 at cycle T -> busy high T+1..T+5; at T+6 hi=0xFFFFFFFF, lo=0xFFFFFFFA, done=1; done=0 at T+7.
- multu a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9(-7), b=2 -> 10 busy cycles, then lo=0xFFFFFFFD(-3), hi=0xFFFFFFFF(-1).
  - divu a=7, b=2 -> lo=3, hi=1.
  - div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0x12345678, then mtlo a=0x9ABCDEF0 on the next cycle, then divu b=0:
  - hi/lo update the cycle after each move, busy never asserted for the moves;
  - divu b=0 gives 10 busy cycles and done, with hi=0x12345678, lo=0x9ABCDEF0 unchanged.
- Mid-op events:
  - start div, then at busy cycle 3 pulse start with mult and change a/b -> ignored; div result from the original operands appears after 10 cycles.
  - Repeat and assert reset at busy cycle 4 -> next cycle busy=0, hi=lo=0, no done pulse.
  - Reserved op 110 with start -> no effect.
